// File: rtl/j1p.sv
// J1P: J1-style stack CPU with one instruction per cycle and stall-on-I/O.
// Sticky stack under/overflow detection is built only when J1P_STACK_CHECK_EN is defined.

module j1p #(
   parameter int WIDTH        = 16,
   parameter int DSTACK_DEPTH = 32,
   parameter int RSTACK_DEPTH = 32
) (
   input  logic             sys_clk_i,
   input  logic             sys_rst_ni,
   output logic [12:0]      code_addr,
   input  logic [15:0]      code_din,
   output logic [12:0]      mem_addr,
   output logic [WIDTH-1:0] mem_dout,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_din,
   output logic             io_rd,
   output logic             io_wr,
   output logic [WIDTH-1:0] io_addr,
   output logic [WIDTH-1:0] io_dout,
   input  logic [WIDTH-1:0] io_din,
   input  logic             io_ack,
   output logic [1:0]       dstk_err,
   output logic [1:0]       rstk_err
);

   localparam int DW = $clog2(DSTACK_DEPTH);
   localparam int RW = $clog2(RSTACK_DEPTH);

   typedef enum logic [1:0] {
      TAG_JMP  = 2'b00,
      TAG_ZBR  = 2'b01,
      TAG_CALL = 2'b10,
      TAG_ALU  = 2'b11
   } tag_e;

   logic [12:0]      pc_q, pc_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic [DW-1:0]    dsp_q, dsp_d;
   logic [RW-1:0]    rsp_q, rsp_d;

   logic [WIDTH-1:0] dstack [DSTACK_DEPTH];
   logic [WIDTH-1:0] rstack [RSTACK_DEPTH];

   logic [WIDTH-1:0] n_w, r_w, alu_res, depth_v, rstk_wdata;
   logic             is_lit, is_alu, io_sel, io_rd_req, io_wr_req, stall, run_en;
   logic             dstk_we, rstk_we;
   logic signed [1:0] dd_s, rd_s;
   logic [3:0]       alu_op;
   tag_e             tag;
   logic             unused_bits;

   assign n_w    = dstack[dsp_q];
   assign r_w    = rstack[rsp_q];
   assign is_lit = code_din[15];
   assign tag    = tag_e'(code_din[14:13]);
   assign is_alu = !is_lit && (tag == TAG_ALU);
   assign alu_op = code_din[11:8];
   assign io_sel = |t_q[WIDTH-1:14];

   // I/O handshake: io_rd/io_wr act as "valid" and stay high while the
   // instruction is re-fetched; io_ack is "ready" and the access retires in
   // the cycle it is high. io_ack is meaningless when no strobe is raised.
   assign io_rd_req = is_alu && (alu_op == 4'hC) && io_sel;
   assign io_wr_req = is_alu && code_din[5] && io_sel;
   assign stall     = (io_rd_req || io_wr_req) && !io_ack;
   assign run_en    = sys_rst_ni && !stall;

   always_comb begin
      depth_v       = '0;
      depth_v[7:0]  = 8'(dsp_q);
      depth_v[15:8] = 8'(rsp_q);
   end

   always_comb begin
      alu_res = t_q;
      case (alu_op)
         4'h0: alu_res = t_q;
         4'h1: alu_res = n_w;
         4'h2: alu_res = t_q + n_w;
         4'h3: alu_res = t_q & n_w;
         4'h4: alu_res = t_q | n_w;
         4'h5: alu_res = t_q ^ n_w;
         4'h6: alu_res = ~t_q;
         4'h7: alu_res = {WIDTH{n_w == t_q}};
         4'h8: alu_res = {WIDTH{$signed(n_w) < $signed(t_q)}};
         4'h9: alu_res = n_w >> t_q[4:0];
         4'hA: alu_res = t_q - WIDTH'(1);
         4'hB: alu_res = r_w;
         4'hC: alu_res = io_sel ? io_din : mem_din;
         4'hD: alu_res = n_w << t_q[4:0];
         4'hE: alu_res = depth_v;
         4'hF: alu_res = {WIDTH{n_w < t_q}};
         default: alu_res = t_q;
      endcase
   end

   always_comb begin
      pc_d       = pc_q + 13'd1;
      t_d        = t_q;
      dd_s       = 2'sb00;
      rd_s       = 2'sb00;
      dstk_we    = 1'b0;
      rstk_we    = 1'b0;
      rstk_wdata = t_q;
      if (!run_en) begin
         // Hold everything so the same instruction is fetched again.
         pc_d = pc_q;
      end else if (is_lit) begin
         t_d     = WIDTH'(code_din[14:0]);
         dd_s    = 2'sb01;
         dstk_we = 1'b1;
      end else begin
         case (tag)
            TAG_JMP: pc_d = code_din[12:0];
            TAG_ZBR: begin
               if (t_q == '0) pc_d = code_din[12:0];
               t_d  = n_w;
               dd_s = 2'sb11;
            end
            TAG_CALL: begin
               pc_d       = code_din[12:0];
               rd_s       = 2'sb01;
               rstk_we    = 1'b1;
               rstk_wdata = WIDTH'({pc_q + 13'd1, 1'b0});
            end
            TAG_ALU: begin
               t_d     = alu_res;
               if (code_din[12]) pc_d = r_w[13:1];
               dd_s    = $signed(code_din[1:0]);
               rd_s    = $signed(code_din[3:2]);
               dstk_we = code_din[7];
               rstk_we = code_din[6];
            end
            default: pc_d = pc_q;
         endcase
      end
   end

   assign dsp_d = dsp_q + DW'(dd_s);
   assign rsp_d = rsp_q + RW'(rd_s);

   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         pc_q  <= '0;
         t_q   <= '0;
         dsp_q <= '0;
         rsp_q <= '0;
      end else begin
         pc_q  <= pc_d;
         t_q   <= t_d;
         dsp_q <= dsp_d;
         rsp_q <= rsp_d;
      end
   end

   // Stack storage carries no reset; pushes land at the post-update pointer.
   always_ff @(posedge sys_clk_i) begin
      if (dstk_we) dstack[dsp_d] <= t_q;
      if (rstk_we) rstack[rsp_d] <= rstk_wdata;
   end

`ifdef J1P_STACK_CHECK_EN
   logic signed [DW+1:0] dsum;
   logic signed [RW+1:0] rsum;
   logic [1:0]           dstk_err_q, rstk_err_q;

   assign dsum = $signed({2'b00, dsp_q}) + (DW+2)'(dd_s);
   assign rsum = $signed({2'b00, rsp_q}) + (RW+2)'(rd_s);

   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         dstk_err_q <= '0;
         rstk_err_q <= '0;
      end else begin
         dstk_err_q <= dstk_err_q | {~dsum[DW+1] & dsum[DW], dsum[DW+1]};
         rstk_err_q <= rstk_err_q | {~rsum[RW+1] & rsum[RW], rsum[RW+1]};
      end
   end

   assign dstk_err = dstk_err_q;
   assign rstk_err = rstk_err_q;
`else
   assign dstk_err = 2'b00;
   assign rstk_err = 2'b00;
`endif

   assign code_addr = sys_rst_ni ? pc_d : 13'd0;
   assign mem_addr  = t_q[13:1];
   assign mem_dout  = n_w;
   assign mem_we    = sys_rst_ni && is_alu && code_din[5] && !io_sel;
   assign io_rd     = sys_rst_ni && io_rd_req;
   assign io_wr     = sys_rst_ni && io_wr_req;
   assign io_addr   = t_q;
   assign io_dout   = n_w;

   assign unused_bits = ^{code_din[4], r_w[0], r_w[WIDTH-1:14]};

endmodule

// File: tb/tb_j1p.sv
// Self-checking bench for j1p: small programs in a code ROM model, T observed on io_addr.
// Error-flag expectations follow J1P_STACK_CHECK_EN.

module tb_j1p;
   localparam int W = 16;

`ifdef J1P_STACK_CHECK_EN
   localparam logic [1:0] EXP_DOVF = 2'b10;
   localparam logic [1:0] EXP_RUNF = 2'b01;
`else
   localparam logic [1:0] EXP_DOVF = 2'b00;
   localparam logic [1:0] EXP_RUNF = 2'b00;
`endif

   logic          sys_clk_i = 1'b0;
   logic          sys_rst_ni;
   logic [12:0]   code_addr;
   logic [15:0]   code_din;
   logic [12:0]   mem_addr;
   logic [W-1:0]  mem_dout;
   logic          mem_we;
   logic [W-1:0]  mem_din;
   logic          io_rd, io_wr;
   logic [W-1:0]  io_addr, io_dout, io_din;
   logic          io_ack;
   logic [1:0]    dstk_err, rstk_err;

   logic [15:0]   imem [0:8191];
   logic [W-1:0]  exp_q [$];
   int            checks = 0;
   int            failures = 0;

   j1p #(.WIDTH(W), .DSTACK_DEPTH(4), .RSTACK_DEPTH(32)) dut (
      .sys_clk_i(sys_clk_i), .sys_rst_ni(sys_rst_ni),
      .code_addr(code_addr), .code_din(code_din),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we), .mem_din(mem_din),
      .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout),
      .io_din(io_din), .io_ack(io_ack),
      .dstk_err(dstk_err), .rstk_err(rstk_err)
   );

   // clock / code ROM
   always #5 sys_clk_i = ~sys_clk_i;
   always @(posedge sys_clk_i) code_din <= imem[code_addr];

   task automatic step();
      @(posedge sys_clk_i);
      #1;
   endtask

   task automatic start();
      sys_rst_ni = 1'b0;
      io_ack = 1'b0;
      repeat (2) @(posedge sys_clk_i);
      #1;
      sys_rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      logic [W-1:0] e;
      imem[0] = 16'h0123;
      exp_q.push_back('0);
      sys_rst_ni = 1'b0;
      io_ack = 1'b1;
      step(); step();
      e = exp_q.pop_front();
      checks++; if (io_addr !== e) begin failures++; $display("FAIL reset_t got=%h exp=%h", io_addr, e); end
      checks++; if (code_addr !== 13'd0) begin failures++; $display("FAIL reset_code_addr got=%h exp=0", code_addr); end
      checks++; if ({io_rd, io_wr, mem_we} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {io_rd, io_wr, mem_we}); end
      checks++; if ({dstk_err, rstk_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {dstk_err, rstk_err}); end
      sys_rst_ni = 1'b1;
      #1;
      checks++; if (code_addr !== 13'h123) begin failures++; $display("FAIL reset_release_fetch got=%h exp=123", code_addr); end
   endtask

   task automatic test_lit_add();
      logic [W-1:0] e;
      imem[0] = 16'h8003; imem[1] = 16'h8004; imem[2] = 16'h6203;
      imem[3] = 16'h6E00; imem[4] = 16'h0004;
      exp_q.push_back(16'h0003); exp_q.push_back(16'h0004);
      exp_q.push_back(16'h0007); exp_q.push_back(16'h0001);
      start();
      for (int k = 0; k < 4; k++) begin
         io_ack = 1'($urandom_range(0, 1));
         step();
         e = exp_q.pop_front();
         checks++; if (io_addr !== e) begin failures++; $display("FAIL lit_add_t[%0d] got=%h exp=%h", k, io_addr, e); end
         if (k == 1) begin
            checks++; if (io_dout !== 16'h0003) begin failures++; $display("FAIL lit_add_n got=%h exp=0003", io_dout); end
         end
      end
      checks++; if (code_addr !== 13'd4) begin failures++; $display("FAIL lit_add_pc got=%h exp=004", code_addr); end
   endtask

   task automatic test_zbranch();
      logic [W-1:0] e;
      imem[0] = 16'h8005; imem[1] = 16'h8000; imem[2] = 16'h2100;
      imem[13'h100] = 16'h8001; imem[13'h101] = 16'h2050;
      imem[13'h102] = 16'h6E00; imem[13'h103] = 16'h0103;
      exp_q.push_back(16'h0005); exp_q.push_back(16'h0000); exp_q.push_back(16'h0005);
      exp_q.push_back(16'h0001); exp_q.push_back(16'h0005); exp_q.push_back(16'h0001);
      start();
      for (int k = 0; k < 6; k++) begin
         step();
         e = exp_q.pop_front();
         checks++; if (io_addr !== e) begin failures++; $display("FAIL zbranch_t[%0d] got=%h exp=%h", k, io_addr, e); end
         if (k == 1) begin
            checks++; if (code_addr !== 13'h100) begin failures++; $display("FAIL zbranch_taken got=%h exp=100", code_addr); end
         end
         if (k == 3) begin
            checks++; if (code_addr !== 13'h102) begin failures++; $display("FAIL zbranch_not_taken got=%h exp=102", code_addr); end
         end
      end
   endtask

   task automatic test_call_ret();
      logic [W-1:0] e;
      imem[0] = 16'h0010; imem[13'h010] = 16'h4200;
      imem[13'h200] = 16'h6E00; imem[13'h201] = 16'h700C;
      imem[13'h011] = 16'h6E00; imem[13'h012] = 16'h0012;
      exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0100);
      exp_q.push_back(16'h0100); exp_q.push_back(16'h0000);
      start();
      for (int k = 0; k < 5; k++) begin
         step();
         e = exp_q.pop_front();
         checks++; if (io_addr !== e) begin failures++; $display("FAIL call_ret_t[%0d] got=%h exp=%h", k, io_addr, e); end
         if (k == 0) begin
            checks++; if (code_addr !== 13'h200) begin failures++; $display("FAIL call_target got=%h exp=200", code_addr); end
         end
         if (k == 2) begin
            checks++; if (code_addr !== 13'h011) begin failures++; $display("FAIL return_pc got=%h exp=011", code_addr); end
         end
      end
   endtask

   task automatic test_io_read();
      logic [W-1:0] e;
      int rd_cnt;
      imem[0] = 16'hC000; imem[1] = 16'h6C00; imem[2] = 16'h0002;
      io_din = 16'hBEEF;
      exp_q.push_back(16'h4000); exp_q.push_back(16'hBEEF);
      rd_cnt = 0;
      start();
      step();
      e = exp_q.pop_front();
      checks++; if (io_addr !== e) begin failures++; $display("FAIL io_rd_addr got=%h exp=%h", io_addr, e); end
      for (int c = 0; c < 4; c++) begin
         io_ack = (c == 3);
         #1;
         if (io_rd === 1'b1) rd_cnt++;
         checks++;
         if (code_addr !== ((c == 3) ? 13'd2 : 13'd1)) begin
            failures++; $display("FAIL io_rd_pc[%0d] got=%h exp=%h", c, code_addr, (c == 3) ? 13'd2 : 13'd1);
         end
         if (c < 3) step();
      end
      step();
      io_ack = 1'b0;
      e = exp_q.pop_front();
      checks++; if (io_addr !== e) begin failures++; $display("FAIL io_rd_data got=%h exp=%h", io_addr, e); end
      checks++; if (rd_cnt !== 4) begin failures++; $display("FAIL io_rd_cycles got=%0d exp=4", rd_cnt); end
      checks++; if (io_rd !== 1'b0) begin failures++; $display("FAIL io_rd_release got=%b exp=0", io_rd); end
   endtask

   task automatic test_store();
      logic [W-1:0] e;
      imem[0] = 16'h80AB; imem[1] = 16'hC000; imem[2] = 16'h6122;
      imem[3] = 16'h8055; imem[4] = 16'h8010; imem[5] = 16'h6122; imem[6] = 16'h0006;
      exp_q.push_back(16'h00AB); exp_q.push_back(16'h4000); exp_q.push_back(16'h00AB);
      exp_q.push_back(16'h0055); exp_q.push_back(16'h0010); exp_q.push_back(16'h0055);
      start();
      io_ack = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         e = exp_q.pop_front();
         checks++; if (io_addr !== e) begin failures++; $display("FAIL store_t[%0d] got=%h exp=%h", k, io_addr, e); end
         if (k == 1) begin
            checks++;
            if ({io_wr, mem_we, io_dout} !== {2'b10, 16'h00AB}) begin
               failures++; $display("FAIL io_store got=%b%b/%h exp=10/00ab", io_wr, mem_we, io_dout);
            end
         end
         if (k == 4) begin
            checks++;
            if ({io_wr, mem_we, mem_addr, mem_dout} !== {2'b01, 13'd8, 16'h0055}) begin
               failures++; $display("FAIL ram_store got=%b%b/%h/%h exp=01/0008/0055", io_wr, mem_we, mem_addr, mem_dout);
            end
         end
      end
      io_ack = 1'b0;
   endtask

   task automatic test_alu_random();
      int ops [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 13, 15};
      for (int i = 0; i < 26; i++) begin
         int op;
         logic [14:0] a, b;
         logic inv;
         logic [W-1:0] n, t, e, g;
         logic [3:0] opc;
         op  = ops[i % 13];
         a   = 15'($urandom_range(0, 32767));
         b   = 15'($urandom_range(0, 32767));
         inv = 1'($urandom_range(0, 1));
         if (op == 7 && $urandom_range(0, 1) == 1) begin inv = 1'b0; b = a; end
         if (op == 9 || op == 13) b = 15'($urandom_range(0, 20));
         n = inv ? ~{1'b0, a} : {1'b0, a};
         t = {1'b0, b};
         case (op)
            0:  e = t;
            1:  e = n;
            2:  e = t + n;
            3:  e = t & n;
            4:  e = t | n;
            5:  e = t ^ n;
            6:  e = ~t;
            7:  e = (n == t) ? 16'hFFFF : 16'h0000;
            8:  e = ($signed(n) < $signed(t)) ? 16'hFFFF : 16'h0000;
            9:  e = n >> t[4:0];
            10: e = t - 16'd1;
            13: e = n << t[4:0];
            default: e = (n < t) ? 16'hFFFF : 16'h0000;
         endcase
         opc = 4'(op);
         imem[0] = {1'b1, a};
         imem[1] = inv ? 16'h6600 : 16'h6000;
         imem[2] = {1'b1, b};
         imem[3] = 16'h6000 | {4'h0, opc, 8'h00} | ((op == 6 || op == 10) ? 16'h0000 : 16'h0003);
         imem[4] = 16'h0004;
         exp_q.push_back(e);
         start();
         repeat (4) begin
            io_ack = 1'($urandom_range(0, 1));
            step();
         end
         g = exp_q.pop_front();
         checks++; if (io_addr !== g) begin failures++; $display("FAIL alu_op%0d n=%h t=%h got=%h exp=%h", op, n, t, io_addr, g); end
      end
   endtask

   task automatic test_stack_wrap();
      logic [W-1:0] e;
      for (int k = 0; k < 5; k++) imem[k] = 16'h8001 + 16'(k);
      imem[5] = 16'h6E00; imem[6] = 16'h0006;
      exp_q.push_back(16'h0001);
      start();
      repeat (3) step();
      checks++; if (dstk_err !== 2'b00) begin failures++; $display("FAIL dstk_before_wrap got=%b exp=00", dstk_err); end
      step();
      checks++; if (dstk_err !== EXP_DOVF) begin failures++; $display("FAIL dstk_overflow got=%b exp=%b", dstk_err, EXP_DOVF); end
      step(); step();
      e = exp_q.pop_front();
      checks++; if (io_addr !== e) begin failures++; $display("FAIL dsp_wrap got=%h exp=%h", io_addr, e); end
      checks++; if (dstk_err !== EXP_DOVF) begin failures++; $display("FAIL dstk_sticky got=%b exp=%b", dstk_err, EXP_DOVF); end
   endtask

   task automatic test_rstack_underflow();
      logic [W-1:0] e;
      imem[0] = 16'h600C; imem[1] = 16'h6E00; imem[2] = 16'h0002;
      exp_q.push_back(16'h1F00);
      start();
      step();
      checks++; if (rstk_err !== EXP_RUNF) begin failures++; $display("FAIL rstk_underflow got=%b exp=%b", rstk_err, EXP_RUNF); end
      step();
      e = exp_q.pop_front();
      checks++; if (io_addr !== e) begin failures++; $display("FAIL rsp_wrap got=%h exp=%h", io_addr, e); end
   endtask

   task automatic test_reset_mid_stall();
      imem[0] = 16'h600C; imem[1] = 16'hC000; imem[2] = 16'h6C00; imem[3] = 16'h0003;
      start();
      step(); step(); step();
      checks++; if ({io_rd, code_addr} !== {1'b1, 13'd2}) begin failures++; $display("FAIL stall_before_reset got=%b/%h exp=1/002", io_rd, code_addr); end
      checks++; if (rstk_err !== EXP_RUNF) begin failures++; $display("FAIL flag_before_reset got=%b exp=%b", rstk_err, EXP_RUNF); end
      sys_rst_ni = 1'b0;
      #1;
      checks++; if (io_rd !== 1'b0) begin failures++; $display("FAIL reset_abort_io_rd got=%b exp=0", io_rd); end
      checks++; if ({code_addr, io_addr} !== {13'd0, 16'h0000}) begin failures++; $display("FAIL reset_abort_state got=%h/%h exp=000/0000", code_addr, io_addr); end
      checks++; if ({dstk_err, rstk_err} !== 4'b0000) begin failures++; $display("FAIL reset_abort_flags got=%b exp=0000", {dstk_err, rstk_err}); end
      step();
      sys_rst_ni = 1'b1;
   endtask

   initial begin
      sys_rst_ni = 1'b0;
      io_ack = 1'b0;
      io_din = '0;
      mem_din = 16'h5A5A;
      for (int i = 0; i < 8192; i++) imem[i] = 16'h0000;
      test_reset();
      test_lit_add();
      test_zbranch();
      test_call_ret();
      test_io_read();
      test_store();
      test_alu_random();
      test_stack_wrap();
      test_rstack_underflow();
      test_reset_mid_stall();
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
